// File: rtl/stk_al_arb.sv
// stk_al_arb: alloc-port arbiter and pointer-return merger for stk_pipe_al.
// Optional counters are enabled with the STK_AL_ARB_STATS_EN macro.
//
// Ports:
//   clk, arst            clock, async active-high reset
//   i_req_vld/o_req_gnt  REQ_N alloc requests / one-hot combinational grant
//   o_rsp_vld_r/_id_r    response valid and requester id, one cycle after grant
//   o_rsp_ptr_r          allocator lookup pointer, passed through while valid
//   i_ret_vld/i_ret_ptr  RET_N pointer-return streams
//   o_ret_rdy            return accepted into the return FIFO this cycle
//   o_ad_alloc           alloc strobe to the allocator
//   i_ad_empty_r         allocator has no free pointers
//   i_ad_busy            allocator initialising
//   i_lk_ptr_w           allocator lookup-stage pointer
//   o_dealloc_vld/_ptr   dealloc port to the allocator (FIFO head)
//   o_stat_alloc_r       grant count (zero unless STK_AL_ARB_STATS_EN)
//   o_stat_stall_r       stall-cycle count (zero unless STK_AL_ARB_STATS_EN)

package stk_pkg;
  localparam int PTR_W = 8;
endpackage

module stk_al_arb #(
  parameter int REQ_N      = 4,
  parameter int RET_N      = 2,
  parameter int RET_FIFO_N = 4,
  parameter int PTR_W      = stk_pkg::PTR_W,
  localparam int ID_W      = (REQ_N > 1) ? $clog2(REQ_N) : 1
) (
  input  logic                   clk,
  input  logic                   arst,
  input  logic [REQ_N-1:0]       i_req_vld,
  output logic [REQ_N-1:0]       o_req_gnt,
  output logic                   o_rsp_vld_r,
  output logic [ID_W-1:0]        o_rsp_id_r,
  output logic [PTR_W-1:0]       o_rsp_ptr_r,
  input  logic [RET_N-1:0]       i_ret_vld,
  input  logic [RET_N*PTR_W-1:0] i_ret_ptr,
  output logic [RET_N-1:0]       o_ret_rdy,
  output logic                   o_ad_alloc,
  input  logic                   i_ad_empty_r,
  input  logic                   i_ad_busy,
  input  logic [PTR_W-1:0]       i_lk_ptr_w,
  output logic                   o_dealloc_vld,
  output logic [PTR_W-1:0]       o_dealloc_ptr,
  output logic [15:0]            o_stat_alloc_r,
  output logic [15:0]            o_stat_stall_r
);

  localparam int AW = $clog2(RET_FIFO_N);

  // ---------------- return FIFO ----------------
  logic [PTR_W-1:0] mem [RET_FIFO_N];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      cnt;
  logic             fifo_full;
  logic             fifo_empty;
  logic             push;
  logic             pop;

  logic [RET_N-1:0] ret_sel;
  logic             ret_any;
  logic [PTR_W-1:0] ret_win;

  assign fifo_full  = (cnt == (AW+1)'(RET_FIFO_N));
  assign fifo_empty = (cnt == '0);

  // Descending scan so the lowest active source is the last one written.
  always_comb begin
    ret_sel = '0;
    ret_any = 1'b0;
    ret_win = '0;
    for (int k = RET_N - 1; k >= 0; k--) begin
      if (i_ret_vld[k]) begin
        ret_sel    = '0;
        ret_sel[k] = 1'b1;
        ret_any    = 1'b1;
        ret_win    = i_ret_ptr[k*PTR_W +: PTR_W];
      end
    end
  end

  // Fullness is judged before this cycle's pop, so a full FIFO
  // never accepts even while it drains.
  assign o_ret_rdy = fifo_full ? '0 : ret_sel;
  assign push      = ret_any & ~fifo_full;

  // The allocator always accepts a dealloc, so issue and pop coincide.
  assign o_dealloc_vld = ~fifo_empty & ~i_ad_busy;
  assign pop           = o_dealloc_vld;
  assign o_dealloc_ptr = o_dealloc_vld ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= ret_win;
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      cnt <= cnt + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
  end

  // ---------------- alloc arbitration ----------------
  logic            can_alloc;
  logic [ID_W-1:0] rr;
  logic [ID_W-1:0] gnt_idx;
  logic [ID_W-1:0] ki;
  logic            hit;
  int              k_rot;

  // A dealloc issued this cycle refills an empty allocator in time
  // for the same-cycle alloc (collision bypass inside the allocator).
  assign can_alloc = ~i_ad_busy & (~i_ad_empty_r | o_dealloc_vld);

  always_comb begin
    o_req_gnt = '0;
    gnt_idx   = '0;
    hit       = 1'b0;
    k_rot     = 0;
    ki        = '0;
    for (int j = 0; j < REQ_N; j++) begin
      k_rot = int'(rr) + j;
      if (k_rot >= REQ_N) begin
        k_rot = k_rot - REQ_N;
      end
      ki = ID_W'(k_rot);
      if (can_alloc && !hit && i_req_vld[ki]) begin
        hit           = 1'b1;
        o_req_gnt[ki] = 1'b1;
        gnt_idx       = ki;
      end
    end
  end

  assign o_ad_alloc = hit;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      rr <= '0;
    end else if (hit) begin
      if (int'(gnt_idx) == REQ_N - 1) begin
        rr <= '0;
      end else begin
        rr <= gnt_idx + 1'b1;
      end
    end
  end

  // ---------------- response ----------------
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      o_rsp_vld_r <= 1'b0;
      o_rsp_id_r  <= '0;
    end else begin
      o_rsp_vld_r <= hit;
      if (hit) begin
        o_rsp_id_r <= gnt_idx;
      end
    end
  end

  // The allocator presents the granted pointer on its lookup stage
  // one cycle after alloc, so the pointer is forwarded, not stored.
  assign o_rsp_ptr_r = o_rsp_vld_r ? i_lk_ptr_w : '0;

  // ---------------- statistics ----------------
`ifdef STK_AL_ARB_STATS_EN
  logic [15:0] stat_alloc;
  logic [15:0] stat_stall;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      stat_alloc <= '0;
      stat_stall <= '0;
    end else begin
      if (hit && stat_alloc != 16'hFFFF) begin
        stat_alloc <= stat_alloc + 16'd1;
      end
      if (!hit && (|i_req_vld) && stat_stall != 16'hFFFF) begin
        stat_stall <= stat_stall + 16'd1;
      end
    end
  end

  assign o_stat_alloc_r = stat_alloc;
  assign o_stat_stall_r = stat_stall;
`else
  assign o_stat_alloc_r = '0;
  assign o_stat_stall_r = '0;
`endif

  // ---------------- checks ----------------
  a_gnt_onehot: assert property (
    @(posedge clk) disable iff (arst) $onehot0(o_req_gnt));

  a_gnt_req: assert property (
    @(posedge clk) disable iff (arst) ((o_req_gnt & ~i_req_vld) == '0));

  a_req_hold: assert property (
    @(posedge clk) disable iff (arst)
    (($past(i_req_vld) & ~$past(o_req_gnt) & ~i_req_vld) == '0));

  a_no_ovf: assert property (
    @(posedge clk) disable iff (arst) !(push && fifo_full));

  a_no_udf: assert property (
    @(posedge clk) disable iff (arst) !(pop && fifo_empty));

  a_cnt_rng: assert property (
    @(posedge clk) disable iff (arst) (cnt <= (AW+1)'(RET_FIFO_N)));

endmodule

// File: tb/tb_stk_al_arb.sv
// tb_stk_al_arb: randomized bench for stk_al_arb with a queue-based model.
// Directed literal checks pin the model; STK_AL_ARB_STATS_EN adds counter tests.

module tb_stk_al_arb;

  localparam int REQ_N = 4;
  localparam int RET_N = 2;
  localparam int FD    = 4;
  localparam int PW    = 8;

  logic          clk = 1'b0;
  logic          arst;
  logic [3:0]    req_vld;
  logic [3:0]    req_gnt;
  logic          rsp_vld;
  logic [1:0]    rsp_id;
  logic [PW-1:0] rsp_ptr;
  logic [1:0]    ret_vld;
  logic [15:0]   ret_ptr;
  logic [1:0]    ret_rdy;
  logic          ad_alloc;
  logic          ad_empty;
  logic          ad_busy;
  logic [PW-1:0] lk_ptr;
  logic          dealloc_vld;
  logic [PW-1:0] dealloc_ptr;
  logic [15:0]   stat_alloc;
  logic [15:0]   stat_stall;

  int n_cmp = 0;
  int n_bad = 0;

  stk_al_arb #(
    .REQ_N(REQ_N), .RET_N(RET_N),
    .RET_FIFO_N(FD), .PTR_W(PW)
  ) dut (
    .clk(clk), .arst(arst),
    .i_req_vld(req_vld), .o_req_gnt(req_gnt),
    .o_rsp_vld_r(rsp_vld), .o_rsp_id_r(rsp_id),
    .o_rsp_ptr_r(rsp_ptr),
    .i_ret_vld(ret_vld), .i_ret_ptr(ret_ptr),
    .o_ret_rdy(ret_rdy), .o_ad_alloc(ad_alloc),
    .i_ad_empty_r(ad_empty), .i_ad_busy(ad_busy),
    .i_lk_ptr_w(lk_ptr),
    .o_dealloc_vld(dealloc_vld),
    .o_dealloc_ptr(dealloc_ptr),
    .o_stat_alloc_r(stat_alloc),
    .o_stat_stall_r(stat_stall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s act=%0h exp=%0h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [PW-1:0] mq[$];
  int            m_rr    = 0;
  bit            m_pend  = 0;
  int            m_id    = 0;
  int            m_alloc = 0;
  int            m_stall = 0;

  logic [3:0]    exp_gnt = '0;
  int            exp_gi  = 0;
  logic [1:0]    exp_rdy = '0;
  logic [PW-1:0] exp_in  = '0;
  bit            exp_dv  = 0;
  logic [PW-1:0] exp_dp  = '0;

  // Outputs are derived from the model state plus current inputs
  // and compared mid-cycle, once inputs have settled.
  always @(negedge clk) begin : cmp
    int  k;
    bit  can;
    exp_dv = (mq.size() != 0) && !ad_busy;
    exp_dp = exp_dv ? mq[0] : '0;
    can    = !ad_busy && (!ad_empty || exp_dv);
    exp_gnt = '0;
    exp_gi  = 0;
    if (can) begin
      for (int j = 0; j < REQ_N; j++) begin
        k = (m_rr + j) % REQ_N;
        if (req_vld[k] && exp_gnt == 0) begin
          exp_gnt[k] = 1'b1;
          exp_gi     = k;
        end
      end
    end
    exp_rdy = '0;
    exp_in  = '0;
    if (mq.size() < FD) begin
      for (int j = 0; j < RET_N; j++) begin
        if (ret_vld[j] && exp_rdy == 0) begin
          exp_rdy[j] = 1'b1;
          exp_in     = ret_ptr[j*PW +: PW];
        end
      end
    end
    chk("gnt", req_gnt, exp_gnt);
    chk("ad_alloc", ad_alloc, exp_gnt != 0);
    chk("ret_rdy", ret_rdy, exp_rdy);
    chk("dealloc_vld", dealloc_vld, exp_dv);
    chk("dealloc_ptr", dealloc_ptr, exp_dp);
    chk("rsp_vld", rsp_vld, m_pend);
    if (m_pend) begin
      chk("rsp_id", rsp_id, m_id);
      chk("rsp_ptr", rsp_ptr, lk_ptr);
    end
`ifdef STK_AL_ARB_STATS_EN
    chk("stat_alloc", stat_alloc, m_alloc);
    chk("stat_stall", stat_stall, m_stall);
`else
    chk("stat_alloc", stat_alloc, 0);
    chk("stat_stall", stat_stall, 0);
`endif
  end

  always @(posedge clk or posedge arst) begin
    if (arst) begin
      mq.delete();
      m_rr    = 0;
      m_pend  = 0;
      m_id    = 0;
      m_alloc = 0;
      m_stall = 0;
    end else begin
      if (exp_dv) void'(mq.pop_front());
      if (exp_rdy != 0) mq.push_back(exp_in);
      m_pend = (exp_gnt != 0);
      if (exp_gnt != 0) begin
        m_rr = (exp_gi + 1) % REQ_N;
        m_id = exp_gi;
        if (m_alloc < 16'hFFFF) m_alloc++;
      end else if (req_vld != 0) begin
        if (m_stall < 16'hFFFF) m_stall++;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic look();
    @(negedge clk);
    #1;
  endtask

  initial begin
    arst     = 1'b1;
    req_vld  = '0;
    ret_vld  = '0;
    ret_ptr  = '0;
    ad_empty = 1'b0;
    ad_busy  = 1'b0;
    lk_ptr   = '0;

    // reset
    look();
    chk("rst_rsp_vld", rsp_vld, 0);
    chk("rst_rsp_id", rsp_id, 0);
    chk("rst_rsp_ptr", rsp_ptr, 0);
    chk("rst_ret_rdy", ret_rdy, 0);
    chk("rst_dealloc", dealloc_vld, 0);
    chk("rst_gnt", req_gnt, 0);
    tick(); tick(); tick();
    arst = 1'b0;

    // round robin
    tick(); req_vld = 4'b1111; lk_ptr = 8'h10;
    look(); chk("rr_g0", req_gnt, 4'b0001);
    chk("rr_rv0", rsp_vld, 0);
    tick(); req_vld = 4'b1110; lk_ptr = 8'h11;
    look(); chk("rr_g1", req_gnt, 4'b0010);
    chk("rr_id0", rsp_id, 0); chk("rr_p0", rsp_ptr, 8'h11);
    tick(); req_vld = 4'b1100; lk_ptr = 8'h12;
    look(); chk("rr_g2", req_gnt, 4'b0100);
    chk("rr_id1", rsp_id, 1); chk("rr_p1", rsp_ptr, 8'h12);
    tick(); req_vld = 4'b1000; lk_ptr = 8'h13;
    look(); chk("rr_g3", req_gnt, 4'b1000);
    chk("rr_id2", rsp_id, 2);
    tick(); req_vld = 4'b0000; lk_ptr = 8'h14;
    look(); chk("rr_id3", rsp_id, 3);
    chk("rr_rv3", rsp_vld, 1); chk("rr_p3", rsp_ptr, 8'h14);
    tick();
    look(); chk("rr_idle", rsp_vld, 0);

    // empty-allocator bypass
    tick(); ad_empty = 1'b1; ret_vld = 2'b01;
    ret_ptr = 16'h002A;
    look(); chk("byp_rdy", ret_rdy, 2'b01);
    chk("byp_nog", req_gnt, 0);
    tick(); ret_vld = 2'b00; req_vld = 4'b0100;
    look(); chk("byp_gnt", req_gnt, 4'b0100);
    chk("byp_dv", dealloc_vld, 1);
    chk("byp_dp", dealloc_ptr, 8'h2A);
    tick(); req_vld = 4'b0000; lk_ptr = 8'h2A;
    look(); chk("byp_rid", rsp_id, 2);
    chk("byp_rptr", rsp_ptr, 8'h2A);
    ad_empty = 1'b0;

    // fill while busy, then drain
    tick(); ad_busy = 1'b1; ret_vld = 2'b01;
    for (int v = 1; v <= 5; v++) begin
      if (v > 1) tick();
      ret_ptr = 16'(v);
      look();
      chk("fill_rdy", ret_rdy, (v <= 4) ? 2'b01 : 2'b00);
      chk("fill_dv", dealloc_vld, 0);
    end
    tick(); ret_vld = 2'b00; ad_busy = 1'b0;
    for (int v = 1; v <= 4; v++) begin
      if (v > 1) tick();
      look();
      chk("drain_dv", dealloc_vld, 1);
      chk("drain_dp", dealloc_ptr, v);
    end
    tick();
    look(); chk("drain_end", dealloc_vld, 0);

    // fixed return priority
    tick(); ret_vld = 2'b11; ret_ptr = 16'h4131;
    look(); chk("pri_0", ret_rdy, 2'b01);
    tick(); ret_ptr = 16'h4132;
    look(); chk("pri_1", ret_rdy, 2'b01);
    tick(); ret_vld = 2'b00;

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      tick();
      if ($urandom_range(0, 399) == 0) begin
        arst    = 1'b1;
        req_vld = '0;
      end else begin
        arst     = 1'b0;
        req_vld  = (req_vld & ~exp_gnt)
                 | 4'($urandom_range(0, 15) & $urandom_range(0, 15));
        ad_busy  = ($urandom_range(0, 7) == 0);
        ad_empty = ($urandom_range(0, 3) == 0);
        ret_vld  = 2'($urandom_range(0, 3));
        ret_ptr  = 16'($urandom);
        lk_ptr   = 8'($urandom);
      end
    end

    // stall counting
    tick(); arst = 1'b1; req_vld = '0; ret_vld = '0;
    tick(); tick();
    tick(); arst = 1'b0; ad_busy = 1'b1; req_vld = 4'b0001;
    for (int i = 0; i < 10; i++) tick();
    look();
`ifdef STK_AL_ARB_STATS_EN
    chk("st_stall10", stat_stall, 16'd10);
    chk("st_alloc0", stat_alloc, 16'd0);
    for (int i = 0; i < 65524; i++) tick();
    look(); chk("st_fffe", stat_stall, 16'hFFFE);
    for (int i = 0; i < 5; i++) tick();
    look(); chk("st_sat", stat_stall, 16'hFFFF);
`else
    chk("st_off_stall", stat_stall, 16'd0);
    chk("st_off_alloc", stat_alloc, 16'd0);
`endif
    tick(); arst = 1'b1; req_vld = '0;
    look();
    chk("st_rst_stall", stat_stall, 0);
    chk("st_rst_alloc", stat_alloc, 0);
    tick(); arst = 1'b0; ad_busy = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
